mult_sequencer: RTL
===================

Name: mult_sequencer

Overview:
- Control FSM for the 8-bit add-shift multiplier datapath: A register, B shift register, X sign bit and 9-bit adder/subtractor.
- On Run, clears A/X, then issues N alternating add/subtract and shift strobes, driven by the multiplier LSB (M) from the B register.
- Also handles the idle-time clear/load request.
- Sits between the top-level switch/button synchronizers and the datapath registers.

Parameters:
- N, 8, operand width; number of add/shift iterations.
- CNT_W, $clog2(N), width of the bit-index counter.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  level start request, already debounced and synchronized.
- ClearA_LoadB  input  1  level request: load B from switches and clear A/X (idle only).
- M  input  1  current multiplier LSB (B[0]).
- Clr_Ld  output  1  one-cycle strobe: B <= switches, A <= 0, X <= 0.
- Clear_XA  output  1  one-cycle strobe: A <= 0, X <= 0; B unchanged.
- Add  output  1  A/X <= A + S, sign-extended to 9 bits.
- Sub  output  1  A/X <= A - S; asserted only on the final iteration.
- Shift_En  output  1  arithmetic right shift of X:A:B as one chain.
- Busy  output  1  high in CLEAR, ADD and SHIFT.
- Done  output  1  high in DONE.
- Bit_Idx  output  CNT_W  current iteration index, 0..N-1.

Behaviour:
- State type: IDLE, CLEAR, ADD, SHIFT, DONE. State and counter are registered. Outputs are decoded from state; Add/Sub also depend on M and Bit_Idx.
- Reset: state <= IDLE, Bit_Idx <= 0. Every strobe, Busy and Done are low in the cycle after Reset is sampled. Reset overrides all other inputs, including mid-operation; the partial product is then undefined and the datapath is not cleared by this block.
- IDLE:
  - Run=1 -> CLEAR.
  - Else ClearA_LoadB=1 -> Clr_Ld high this cycle; remain IDLE. Clr_Ld stays high every cycle the request is held.
  - Run takes priority over ClearA_LoadB when both are high.
- CLEAR: Clear_XA=1 for one cycle; Bit_Idx <= 0; -> ADD.
- ADD:
  - If M=1 and Bit_Idx<N-1: Add=1.
  - If M=1 and Bit_Idx==N-1: Sub=1 (two's-complement sign correction).
  - If M=0: no strobe.
  - Always -> SHIFT.
- SHIFT: Shift_En=1.
  - If Bit_Idx==N-1 -> DONE; Bit_Idx holds.
  - Else Bit_Idx <= Bit_Idx+1; -> ADD.
- DONE:
  - Done=1; no strobes.
  - Stays while Run=1; -> IDLE when Run=0.
  - ClearA_LoadB is ignored in DONE.
- Latency: if Run is sampled high at edge 0, CLEAR is active in cycle 1 and ADD0..SHIFT(N-1) occupy cycles 2..2N+1. Done is first high in cycle 2N+2, which is cycle 18 for N=8.
- Mutual exclusion: at most one of Clr_Ld, Clear_XA, Add, Sub, Shift_En is high in any cycle. Add and Sub are never both high.
- Run is not rearmed: holding Run high through DONE does not restart. A new multiply needs Run to go low, return to IDLE, then go high again.
- Run toggling during Busy is ignored. ClearA_LoadB during Busy is ignored.
- Bit_Idx increments only in SHIFT, never wraps past N-1 within a run, and is 0 in IDLE after reset.
- Any unreachable encoding -> IDLE on the next clock.

Decomposition:
- Package mult_pkg holds:
  - the state enum typedef mult_state_t (5 states);
  - localparam defaults for N and CNT_W, shared with the datapath registers.
- Optional sub-module mult_bit_counter: CNT_W-bit counter with clr, inc and last (==N-1) flag.
- FSM and output decode live in mult_sequencer.

Test Plan:
- Reset for 2 cycles, Run=0 -> IDLE; all strobes, Busy, Done and Bit_Idx are 0.
- Idle with ClearA_LoadB=1 for 3 cycles, Run=0 -> Clr_Ld high for exactly 3 cycles; no other strobe; state stays IDLE.
- Run pulse with M held 1 -> Clear_XA at cycle 1; Add at cycles 2,4,...,14; Sub at cycle 16; Shift_En at cycles 3,5,...,17; Done at cycle 18; Bit_Idx reads 0..7.
- Run held high with M held 0 -> no Add/Sub across all 8 ADD cycles; 8 Shift_En pulses; Done stays high until Run=0, then IDLE; no restart while Run stays high.
- Reset asserted at cycle 9 of a run -> next cycle IDLE, Bit_Idx=0, Busy=0, no strobes; a fresh Run then gives the full 18-cycle sequence.
- Run and ClearA_LoadB high together in IDLE -> CLEAR path taken; Clr_Ld never asserts. Scoreboard checks a -7 x 5 product of -35 (0xFFDD) against a behavioural datapath model.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg
//   Types and default sizes shared by the add-shift multiplier sequencer
//   and its datapath registers.
//   - MULT_N       : operand width / number of add-shift iterations
//   - MULT_CNT_W   : width of the iteration index counter
//   - mult_state_t : sequencer state encoding
package mult_pkg;

    localparam int MULT_N     = 8;
    localparam int MULT_CNT_W = $clog2(MULT_N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter
//   Iteration index for the multiplier sequencer. Saturates at N-1 so the
//   index can never wrap within a run.
//   Ports:
//     Clk, Reset : clock, synchronous active-high reset
//     clr        : force count to 0
//     inc        : advance by one (ignored once count reaches N-1)
//     count      : current index
//     last       : count == N-1
module mult_bit_counter #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == CNT_W'(N - 1));

    always_ff @(posedge Clk) begin
        if (Reset || clr)
            count <= '0;
        else if (inc && !last)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Control FSM for the signed add-shift multiplier (A register, B shift
//   register, X sign bit, 9-bit adder/subtractor). On Run it clears A/X,
//   then performs N add-or-skip / shift iterations steered by the
//   multiplier LSB M; the last iteration subtracts instead of adding to
//   correct for the two's-complement sign weight of the multiplier MSB.
//   While idle it also serves the clear-A / load-B request.
//   Ports:
//     Clk, Reset    : clock, synchronous active-high reset
//     Run           : level start request (synchronized)
//     ClearA_LoadB  : level request to load B and clear A/X (idle only)
//     M             : current multiplier LSB, B[0]
//     Clr_Ld        : strobe B <= switches, A/X <= 0
//     Clear_XA      : strobe A/X <= 0
//     Add / Sub     : strobe A/X <= A +/- S
//     Shift_En      : arithmetic right shift of X:A:B
//     Busy / Done   : status
//     Bit_Idx       : current iteration index
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N     = MULT_N,
    parameter int CNT_W = $clog2(N)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             M,
    output logic             Clr_Ld,
    output logic             Clear_XA,
    output logic             Add,
    output logic             Sub,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Bit_Idx
);

    mult_state_t state;
    logic        last;

    mult_bit_counter #(.N(N), .CNT_W(CNT_W)) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (state == CLEAR),
        .inc   (state == SHIFT),
        .count (Bit_Idx),
        .last  (last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (Run) state <= CLEAR;
                CLEAR:   state <= ADD;
                ADD:     state <= SHIFT;
                SHIFT:   state <= last ? DONE : ADD;
                // No rearm: Run must drop before another multiply starts.
                DONE:    if (!Run) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so each lands in the same cycle as the
    // state that owns it; Run wins over the load request in IDLE.
    always_comb begin
        Clr_Ld   = 1'b0;
        Clear_XA = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE:  Clr_Ld = ClearA_LoadB && !Run;
            CLEAR: begin
                Clear_XA = 1'b1;
                Busy     = 1'b1;
            end
            ADD: begin
                Add  = M && !last;
                Sub  = M && last;
                Busy = 1'b1;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

endmodule
